// File: rtl/wta_pkg.sv
// Shared types, width helpers and a reference lowest-index encoder for the WTA gamma sequencer.
package wta_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   localparam int G_DEF = 16;
   localparam int N_DEF = 16;

   // A single value still needs one bit, so clog2 results are floored at 1.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   localparam int TW_DEF = clog2_min1(G_DEF);
   localparam int IW_DEF = clog2_min1(N_DEF);

   function automatic logic [IW_DEF-1:0] lowest_set_idx(input logic [N_DEF-1:0] v);
      logic [IW_DEF-1:0] r;
      r = '0;
      for (int i = N_DEF - 1; i >= 0; i--) begin
         if (v[i]) r = IW_DEF'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/wta_gamma_sched_prio_enc.sv
// Lowest-index-wins priority encoder; vld flags any request set. Purely combinational.
module prio_enc #(
   parameter int N  = 16,
   parameter int IW = 4
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          vld
);

   always_comb begin
      idx = '0;
      vld = |req;
      // Walk downwards so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/wta_gamma_sched.sv
// Gamma-cycle sequencer: gates spikes into the WTA, captures the first winner per gamma and
// hands it to a consumer over valid/ready, counting results lost while the consumer stalls.
module wta_gamma_sched
   import wta_pkg::*;
#(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int NUM_INPUTS        = 16,
   localparam int TW = clog2_min1(GAMMA_CYCLE_WIDTH),
   localparam int IW = clog2_min1(NUM_INPUTS)
) (
   input  logic                  aclk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [NUM_INPUTS-1:0] input_spikes,
   output logic [NUM_INPUTS-1:0] wta_in_spikes,
   input  logic [NUM_INPUTS-1:0] wta_out_spikes,
   output logic                  wta_clr,
   output logic                  gamma_start,
   output logic [TW-1:0]         gamma_t,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [IW-1:0]         res_idx,
   output logic [TW-1:0]         res_time,
   output logic                  res_none,
   output logic [7:0]            drop_cnt
);

   localparam logic [TW-1:0] T_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [TW-1:0] T_CLR  = TW'(GAMMA_CYCLE_WIDTH - PULSE_WIDTH);

   state_e                  state_q, state_d;
   logic [TW-1:0]           t_q, t_d;
   logic [NUM_INPUTS-1:0]   prev_q, prev_d;
   logic                    cap_q, cap_d;
   logic [IW-1:0]           cap_idx_q, cap_idx_d;
   logic [TW-1:0]           cap_time_q, cap_time_d;
   logic                    res_valid_q, res_valid_d;
   logic [IW-1:0]           res_idx_q, res_idx_d;
   logic [TW-1:0]           res_time_q, res_time_d;
   logic                    res_none_q, res_none_d;
   logic [7:0]              drop_q, drop_d;

   logic                    run, last, accept, new_cap, hit;
   logic [NUM_INPUTS-1:0]   rise;
   logic [IW-1:0]           rise_idx;
   logic                    rise_vld;

   assign run  = (state_q == RUN);
   assign last = run && (t_q == T_LAST);
   assign rise = wta_out_spikes & ~prev_q;

   prio_enc #(.N(NUM_INPUTS), .IW(IW)) u_rise_enc (
      .req (rise),
      .idx (rise_idx),
      .vld (rise_vld)
   );

   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      prev_d      = '0;
      cap_d       = cap_q;
      cap_idx_d   = cap_idx_q;
      cap_time_d  = cap_time_q;
      res_valid_d = res_valid_q;
      res_idx_d   = res_idx_q;
      res_time_d  = res_time_q;
      res_none_d  = res_none_q;
      drop_d      = drop_q;

      accept  = res_valid_q && res_ready;
      new_cap = run && !cap_q && rise_vld;
      hit     = cap_q || new_cap;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RUN;
               t_d     = '0;
            end
         end
         RUN: begin
            if (last) begin
               t_d = '0;
               if (!enable) state_d = IDLE;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // prev is zero entering t==0, so a level held across the gamma boundary re-registers as a rise.
      if (run && !last) prev_d = wta_out_spikes;

      if (new_cap) begin
         cap_d      = 1'b1;
         cap_idx_d  = rise_idx;
         cap_time_d = t_q;
      end
      if (last) cap_d = 1'b0;

      if (last) begin
         if (!res_valid_q || accept) begin
            res_valid_d = 1'b1;
            res_none_d  = !hit;
            res_idx_d   = !hit ? '0 : (cap_q ? cap_idx_q : rise_idx);
            res_time_d  = !hit ? '0 : (cap_q ? cap_time_q : t_q);
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end else if (accept) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         t_q         <= '0;
         prev_q      <= '0;
         cap_q       <= 1'b0;
         cap_idx_q   <= '0;
         cap_time_q  <= '0;
         res_valid_q <= 1'b0;
         res_idx_q   <= '0;
         res_time_q  <= '0;
         res_none_q  <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         prev_q      <= prev_d;
         cap_q       <= cap_d;
         cap_idx_q   <= cap_idx_d;
         cap_time_q  <= cap_time_d;
         res_valid_q <= res_valid_d;
         res_idx_q   <= res_idx_d;
         res_time_q  <= res_time_d;
         res_none_q  <= res_none_d;
         drop_q      <= drop_d;
      end
   end

   assign gamma_start   = run && (t_q == '0);
   assign wta_clr       = !run || (t_q >= T_CLR);
   assign wta_in_spikes = (run && (t_q < T_CLR)) ? input_spikes : '0;
   assign gamma_t       = t_q;
   assign res_valid     = res_valid_q;
   assign res_idx       = res_idx_q;
   assign res_time      = res_time_q;
   assign res_none      = res_none_q;
   assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_wta_gamma_sched.sv
// Bench for wta_gamma_sched: vector table, directed gamma sequences and random traffic vs a history-based model.
module tb_wta_gamma_sched;

   localparam int G = 16;
   localparam int P = 8;
   localparam int N = 16;

   logic        aclk = 1'b0;
   logic        rst  = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] input_spikes = '0;
   logic [15:0] wta_out_spikes = '0;
   logic        res_ready = 1'b0;
   logic [15:0] wta_in_spikes;
   logic        wta_clr, gamma_start, res_valid, res_none;
   logic [3:0]  gamma_t, res_idx, res_time;
   logic [7:0]  drop_cnt;

   always #5 aclk = ~aclk;

   wta_gamma_sched #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P), .NUM_INPUTS(N)) dut (
      .aclk           (aclk),
      .rst            (rst),
      .enable         (enable),
      .input_spikes   (input_spikes),
      .wta_in_spikes  (wta_in_spikes),
      .wta_out_spikes (wta_out_spikes),
      .wta_clr        (wta_clr),
      .gamma_start    (gamma_start),
      .gamma_t        (gamma_t),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_idx        (res_idx),
      .res_time       (res_time),
      .res_none       (res_none),
      .drop_cnt       (drop_cnt)
   );

   int total  = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else passed++;
   endtask

   // Reference model: records each gamma's WTA output history and scans it once the gamma ends.
   bit          m_run  = 0;
   int          m_t    = 0;
   bit          m_rv   = 0;
   int          m_idx  = 0;
   int          m_time = 0;
   bit          m_none = 0;
   int          m_drop = 0;
   logic [15:0] hist [G];

   always @(posedge aclk or posedge rst) begin
      bit acc;
      bit found;
      int wi, wt;
      logic [15:0] r;
      if (rst) begin
         m_run = 0; m_t = 0; m_rv = 0; m_idx = 0; m_time = 0; m_none = 0; m_drop = 0;
      end else begin
         acc = m_rv && res_ready;
         if (!m_run) begin
            if (acc) m_rv = 0;
            if (enable) begin m_run = 1; m_t = 0; end
         end else begin
            hist[m_t] = wta_out_spikes;
            if (m_t == G - 1) begin
               found = 0; wi = 0; wt = 0;
               for (int tt = 0; tt < G; tt++) begin
                  if (tt == 0) r = hist[0];
                  else         r = hist[tt] & ~hist[tt-1];
                  if (!found && r != 0) begin
                     found = 1; wt = tt;
                     for (int b = N - 1; b >= 0; b--) if (r[b]) wi = b;
                  end
               end
               if (!m_rv || acc) begin
                  m_rv = 1; m_none = !found; m_idx = wi; m_time = wt;
               end else if (m_drop < 255) begin
                  m_drop++;
               end
               m_t = 0;
               if (!enable) m_run = 0;
            end else begin
               if (acc) m_rv = 0;
               m_t++;
            end
         end
      end
   end

   task automatic cmp_model();
      chk("gamma_start", 32'(gamma_start), 32'(m_run && m_t == 0));
      chk("wta_clr", 32'(wta_clr), 32'(!m_run || m_t >= G - P));
      chk("wta_in_spikes", 32'(wta_in_spikes), 32'((m_run && m_t < G - P) ? input_spikes : 16'h0));
      chk("gamma_t", 32'(gamma_t), 32'(m_t));
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (m_rv) begin
         chk("res_idx", 32'(res_idx), 32'(m_idx));
         chk("res_time", 32'(res_time), 32'(m_time));
         chk("res_none", 32'(res_none), 32'(m_none));
      end
   endtask

   // Drive one cycle's inputs in the low phase, compare, then move to the next falling edge.
   task automatic step(input logic en, input logic [15:0] inp, input logic [15:0] wo, input logic rdy);
      enable = en; input_spikes = inp; wta_out_spikes = wo; res_ready = rdy;
      #1;
      cmp_model();
      @(negedge aclk);
   endtask

   task automatic do_gamma(input int spike_t, input logic [15:0] spike, input int rdy_t);
      for (int t = 0; t < G; t++)
         step(1'b1, 16'($urandom), (t == spike_t) ? spike : 16'h0, (t == rdy_t));
   endtask

   typedef struct {
      logic        en;
      logic [15:0] inp;
      logic [15:0] wo;
      logic        start;
      logic        clr;
      logic [15:0] win;
      logic [3:0]  t;
   } vec_t;

   vec_t tbl [17];

   initial begin
      // Row 0 is the IDLE cycle that sees enable; rows 1..16 are t=0..15 of the first gamma.
      for (int i = 0; i < 17; i++) begin
         tbl[i].en    = 1'b1;
         tbl[i].inp   = 16'h0;
         tbl[i].wo    = 16'h0;
         tbl[i].start = (i == 1);
         tbl[i].clr   = (i == 0) || (i >= 9);
         tbl[i].win   = 16'h0;
         tbl[i].t     = (i == 0) ? 4'd0 : 4'(i - 1);
      end
      tbl[3].inp  = 16'h0002; tbl[3].win = 16'h0002;
      tbl[11].inp = 16'h0002;
      tbl[4].wo   = 16'h0020; tbl[5].wo  = 16'h0020;
      tbl[7].wo   = 16'h1000; tbl[8].wo  = 16'h1000;

      #2 rst = 1'b1;
      @(negedge aclk); @(negedge aclk);
      #1;
      chk("rst_clr", 32'(wta_clr), 32'd1);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_start", 32'(gamma_start), 32'd0);
      chk("rst_t", 32'(gamma_t), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      @(negedge aclk);

      for (int i = 0; i < 17; i++) begin
         enable = tbl[i].en; input_spikes = tbl[i].inp; wta_out_spikes = tbl[i].wo; res_ready = 1'b0;
         #1;
         chk("tbl_start", 32'(gamma_start), 32'(tbl[i].start));
         chk("tbl_clr", 32'(wta_clr), 32'(tbl[i].clr));
         chk("tbl_win", 32'(wta_in_spikes), 32'(tbl[i].win));
         chk("tbl_t", 32'(gamma_t), 32'(tbl[i].t));
         cmp_model();
         @(negedge aclk);
      end
      #1;
      chk("g1_valid", 32'(res_valid), 32'd1);
      chk("g1_idx", 32'(res_idx), 32'd5);
      chk("g1_time", 32'(res_time), 32'd3);
      chk("g1_none", 32'(res_none), 32'd0);

      do_gamma(4, 16'h0204, 0);
      chk("g2_idx", 32'(res_idx), 32'd2);
      chk("g2_time", 32'(res_time), 32'd4);
      chk("g2_valid", 32'(res_valid), 32'd1);
      do_gamma(-1, 16'h0, 0);
      chk("g3_none", 32'(res_none), 32'd1);
      chk("g3_idx", 32'(res_idx), 32'd0);
      chk("g3_time", 32'(res_time), 32'd0);

      do_gamma(7, 16'h0008, -1);
      chk("g4_held_none", 32'(res_none), 32'd1);
      chk("g4_drop", 32'(drop_cnt), 32'd1);
      do_gamma(2, 16'h0100, G - 1);
      chk("g5_valid", 32'(res_valid), 32'd1);
      chk("g5_idx", 32'(res_idx), 32'd8);
      chk("g5_time", 32'(res_time), 32'd2);

      for (int t = 0; t < G; t++)
         step(t < 5, 16'hFFFF, (t == 9) ? 16'h0008 : 16'h0, (t == 0));
      chk("g6_idx", 32'(res_idx), 32'd3);
      chk("g6_time", 32'(res_time), 32'd9);
      chk("g6_idle_clr", 32'(wta_clr), 32'd1);
      chk("g6_idle_start", 32'(gamma_start), 32'd0);
      step(1'b0, 16'hFFFF, 16'h0, 1'b0);
      step(1'b0, 16'hFFFF, 16'h0, 1'b0);

      step(1'b1, 16'h0, 16'h0, 1'b0);
      for (int t = 0; t < 6; t++) step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      input_spikes = 16'hFFFF;
      rst = 1'b1;
      #1;
      chk("mrst_t", 32'(gamma_t), 32'd0);
      chk("mrst_clr", 32'(wta_clr), 32'd1);
      chk("mrst_win", 32'(wta_in_spikes), 32'd0);
      chk("mrst_valid", 32'(res_valid), 32'd0);
      chk("mrst_drop", 32'(drop_cnt), 32'd0);
      chk("mrst_idx", 32'(res_idx), 32'd0);
      cmp_model();
      @(negedge aclk);
      rst = 1'b0;

      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b1; #1; cmp_model(); rst = 1'b0;
         end
         step($urandom_range(0, 7) != 0, 16'($urandom),
              16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)));
      end

      for (int c = 0; c < 265 * G; c++)
         step(1'b1, 16'($urandom), 16'($urandom & $urandom), 1'b0);
      chk("drop_sat", 32'(drop_cnt), 32'd255);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/wta_gamma_sched.md
Name: wta_gamma_sched

Overview:
- Gamma-cycle sequencer for a 1-WTA column (wta_1); sits between the spike sources and the WTA datapath.
- Divides time into gamma cycles of GAMMA_CYCLE_WIDTH clocks: a spike window, then a clear phase that drains pulses.
- Gates input spikes into the WTA and captures the first winner (index and time) per gamma.
- Hands each gamma's result to a consumer over a valid/ready interface.

Parameters:
GAMMA_CYCLE_WIDTH, 16, clocks per gamma cycle (G).
PULSE_WIDTH, 8, spike pulse length in clocks (P); clear phase = last P clocks of each gamma; must satisfy 0 < P < G.
NUM_INPUTS, 16, number of spike lines (N).

Ports:
aclk  in  1  clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  run request
input_spikes  in  N  raw spike pulses from sources
wta_in_spikes  out  N  gated spikes driven to WTA
wta_out_spikes  in  N  WTA output spikes
wta_clr  out  1  WTA clear/inhibit phase
gamma_start  out  1  high during t==0 of each running gamma
gamma_t  out  clog2(G)  current gamma time t
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_idx  out  clog2(N)  winner index
res_time  out  clog2(G)  winner spike time t
res_none  out  1  no winner this gamma
drop_cnt  out  8  saturating count of results lost to backpressure

Behaviour:
- Reset: state IDLE, t=0, all outputs 0 except wta_clr=1; capture and result registers cleared.
- States: IDLE, RUN.
  - IDLE -> RUN on enable=1; first RUN cycle has t=0.
  - In RUN, t increments each clock and wraps G-1 -> 0.
  - enable=0 sampled mid-gamma: gamma completes through t=G-1, then IDLE. No abort.
  - enable=1 at t=G-1: next gamma starts immediately with no gap.
- Outputs are decoded from registered state and t:
  - gamma_start = RUN && t==0.
  - wta_clr = IDLE || t >= G-P.
  - wta_in_spikes = input_spikes when RUN && t < G-P, else 0.
- Winner capture in RUN:
  - prev register holds wta_out_spikes from the last cycle; rise = wta_out_spikes & ~prev.
  - The first cycle in a gamma with rise != 0 latches idx = lowest set bit of rise, time = t, and sets the captured flag.
  - Later rises in the same gamma are ignored.
  - captured clears at the t=G-1 edge.
  - prev is cleared to 0 at t==0 so a spike held across the boundary still counts.
  - A capture landing at t==G-1 is included in that gamma's result.
- Result commit on the clock edge where t==G-1:
  - res_idx/res_time take the captured values; res_none = !captured (idx=0, time=0 when none).
  - res_valid=1 from the next cycle on.
- Handshake:
  - res_valid stays high and res_* stay stable until res_valid && res_ready.
  - Accept without commit in the same cycle: res_valid -> 0.
  - Accept and commit in the same cycle: new result loads and res_valid stays 1.
  - Commit while res_valid=1 with no accept: new result discarded, old result kept, drop_cnt += 1 (saturates at 255).
- rst mid-gamma: immediate return to reset values; any pending result is lost.
- Widths: clog2 values use a minimum width of 1; t compare uses G-P computed as a constant.

Decomposition:
- wta_pkg:
  - state enum (IDLE, RUN).
  - Width constants derived from G and N.
  - Function lowest_set_idx(N-bit) -> clog2(N).
- Sub-module prio_enc: parameterised N-input lowest-index priority encoder with a valid output. Used for rise detection.

Test Plan:
(All scenarios use G=16, P=8, N=16.)
1. Reset, then enable=1 -> gamma_start=1 at t=0; wta_clr=0 for t=0..7 and 1 for t=8..15; input_spikes bit1 high at t=10 -> wta_in_spikes=0; bit1 high at t=2 -> passes through.
2. wta_out_spikes bit5 rises at t=3 -> one cycle after t=15: res_valid=1, res_idx=5, res_time=3, res_none=0; a bit12 rise at t=6 is ignored.
3. Bits 2 and 9 rise together at t=4 -> res_idx=2, res_time=4. No spikes in the next gamma -> res_none=1, res_idx=0, res_time=0.
4. res_ready=0 across two gamma ends -> first result held unchanged, drop_cnt=1. res_ready=1 in the commit cycle of the next gamma -> new result loads and res_valid stays 1.
5. enable dropped at t=5 -> t continues to 15, result committed, then IDLE with wta_clr=1 and gamma_start=0. rst pulsed at t=6 in a later run -> all outputs at reset values and drop_cnt=0.
